// File: rtl/ipsxe_floating_point_horner_seq_v1_0.sv
// Iterative Horner-scheme sequencer for polynomial approximation.
// Evaluates p(z) = c0 + z*(c1 + z*(... + z*c[N-1])) by issuing one
// multiply-add step per coefficient to an external fixed-latency MAC
// (P = Z + X*Y) and feeding each result back as the next multiplicand.
//
// Handshakes: a transfer happens on a rising clock edge where valid and
// ready are both high. A producer holds valid and its payload stable until
// that edge. On the request side this block is the consumer (o_ready).
// On the result side it is the producer (o_valid, o_result).
module ipsxe_floating_point_horner_seq_v1_0 #(
  parameter int COEF_WIDTH  = 22,
  parameter int Z_WIDTH     = 9,
  parameter int ACC_WIDTH   = 47,
  parameter int NUM_COEF    = 4,
  parameter int MAC_LATENCY = 2,
  parameter int MUL_SHIFT   = 25
) (
  input  logic                           i_clk,
  input  logic                           i_rst_n,
  input  logic                           i_valid,
  output logic                           o_ready,
  input  logic [Z_WIDTH-1:0]             i_z,
  input  logic [NUM_COEF*COEF_WIDTH-1:0] i_coefs,
  output logic                           o_mac_vld,
  output logic [COEF_WIDTH-1:0]          o_mac_x,
  output logic [Z_WIDTH-1:0]             o_mac_y,
  output logic [ACC_WIDTH-1:0]           o_mac_z,
  input  logic [ACC_WIDTH-1:0]           i_mac_p,
  output logic                           o_valid,
  input  logic                           i_ready,
  output logic [ACC_WIDTH-1:0]           o_result,
  output logic [1:0]                     o_dbg_state
);

  // Coefficient index runs N-2 down to 0; wait counter runs 0..MAC_LATENCY-1.
  localparam int K_W    = (NUM_COEF > 1) ? $clog2(NUM_COEF) : 1;
  localparam int K_INIT = (NUM_COEF > 1) ? NUM_COEF - 2 : 0;
  localparam int CNT_W  = (MAC_LATENCY > 1) ? $clog2(MAC_LATENCY) : 1;
  localparam int PAD_W  = ACC_WIDTH - COEF_WIDTH;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                         r_state;
  logic [Z_WIDTH-1:0]             r_z;
  logic [NUM_COEF*COEF_WIDTH-1:0] r_coefs;
  logic [ACC_WIDTH-1:0]           r_acc;
  logic [K_W-1:0]                 r_k;
  logic [CNT_W-1:0]               r_cnt;
  logic                           r_mac_vld;
  logic [COEF_WIDTH-1:0]          r_mac_x;
  logic [Z_WIDTH-1:0]             r_mac_y;
  logic [ACC_WIDTH-1:0]           r_mac_z;
  logic                           r_valid;
  logic [ACC_WIDTH-1:0]           r_result;

  state_t                         w_state_nxt;
  logic [Z_WIDTH-1:0]             w_z_nxt;
  logic [NUM_COEF*COEF_WIDTH-1:0] w_coefs_nxt;
  logic [ACC_WIDTH-1:0]           w_acc_nxt;
  logic [K_W-1:0]                 w_k_nxt;
  logic [CNT_W-1:0]               w_cnt_nxt;
  logic [COEF_WIDTH-1:0]          w_coef_top;
  logic [COEF_WIDTH-1:0]          w_coef_sel;

  // Highest coefficient seeds the accumulator on accept.
  assign w_coef_top = i_coefs[(NUM_COEF-1)*COEF_WIDTH +: COEF_WIDTH];

  // Next-state, accumulator, index and wait-counter updates.
  always_comb begin
    w_state_nxt = r_state;
    w_z_nxt     = r_z;
    w_coefs_nxt = r_coefs;
    w_acc_nxt   = r_acc;
    w_k_nxt     = r_k;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (i_valid) begin
          w_z_nxt     = i_z;
          w_coefs_nxt = i_coefs;
          w_acc_nxt   = {{PAD_W{1'b0}}, w_coef_top};
          w_k_nxt     = K_W'(K_INIT);
          w_state_nxt = (NUM_COEF == 1) ? S_DONE : S_ISSUE;
        end
      end
      S_ISSUE: begin
        w_cnt_nxt   = '0;
        w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        w_cnt_nxt = r_cnt + CNT_W'(1);
        // The MAC result is only trusted on the MAC_LATENCY-th cycle after issue.
        if (r_cnt == CNT_W'(MAC_LATENCY - 1)) begin
          w_acc_nxt = i_mac_p;
          if (r_k == '0) begin
            w_state_nxt = S_DONE;
          end else begin
            w_k_nxt     = r_k - K_W'(1);
            w_state_nxt = S_ISSUE;
          end
        end
      end
      S_DONE: begin
        if (i_ready) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Addend for the next issue: coefficient at the upcoming index.
  always_comb begin
    w_coef_sel = '0;
    for (int i = 0; i < NUM_COEF; i++) begin
      if (w_k_nxt == K_W'(i)) begin
        w_coef_sel = w_coefs_nxt[i*COEF_WIDTH +: COEF_WIDTH];
      end
    end
  end

  // State, datapath and registered output updates; reset has priority.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state   <= S_IDLE;
      r_z       <= '0;
      r_coefs   <= '0;
      r_acc     <= '0;
      r_k       <= '0;
      r_cnt     <= '0;
      r_mac_vld <= 1'b0;
      r_mac_x   <= '0;
      r_mac_y   <= '0;
      r_mac_z   <= '0;
      r_valid   <= 1'b0;
      r_result  <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_z       <= w_z_nxt;
      r_coefs   <= w_coefs_nxt;
      r_acc     <= w_acc_nxt;
      r_k       <= w_k_nxt;
      r_cnt     <= w_cnt_nxt;
      // MAC operands are registered on entry to ISSUE and held otherwise.
      r_mac_vld <= (w_state_nxt == S_ISSUE);
      if (w_state_nxt == S_ISSUE) begin
        r_mac_x <= w_acc_nxt[MUL_SHIFT +: COEF_WIDTH];
        r_mac_y <= w_z_nxt;
        r_mac_z <= {{PAD_W{1'b0}}, w_coef_sel};
      end
      // Result is captured once on entry to DONE and stays put under backpressure.
      r_valid <= (w_state_nxt == S_DONE);
      if ((w_state_nxt == S_DONE) && (r_state != S_DONE)) begin
        r_result <= w_acc_nxt;
      end
    end
  end

  assign o_ready     = (r_state == S_IDLE);
  assign o_mac_vld   = r_mac_vld;
  assign o_mac_x     = r_mac_x;
  assign o_mac_y     = r_mac_y;
  assign o_mac_z     = r_mac_z;
  assign o_valid     = r_valid;
  assign o_result    = r_result;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_ipsxe_floating_point_horner_seq_v1_0.sv
// Bench for the Horner sequencer: four instances (N/latency variants, all with
// MUL_SHIFT=0), each paired with a behavioural multiply-add model.
module tb_ipsxe_floating_point_horner_seq_v1_0;

  localparam int CW   = 22;
  localparam int ZW   = 9;
  localparam int AW   = 47;
  localparam int NMAX = 4;
  localparam int NI   = 4;

  // Clock and reset
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;
  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic               valid  [NI];
  logic               rdy    [NI];
  logic [ZW-1:0]      z      [NI];
  logic [NMAX*CW-1:0] coefs  [NI];
  logic               mac_vld[NI];
  logic [CW-1:0]      mac_x  [NI];
  logic [ZW-1:0]      mac_y  [NI];
  logic [AW-1:0]      mac_z  [NI];
  logic [AW-1:0]      mac_p  [NI];
  logic               ovalid [NI];
  logic               iready [NI];
  logic [AW-1:0]      result [NI];
  logic [1:0]         dbg    [NI];

  int n_of  [NI] = '{4, 1, 4, 4};
  int lat_of[NI] = '{2, 2, 1, 4};

  int errors = 0;
  int checks = 0;

  // Per-instance DUT and MAC model; MAC output is junk except when a result is due.
  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int N   = (g == 1) ? 1 : 4;
    localparam int LAT = (g == 2) ? 1 : ((g == 3) ? 4 : 2);
    logic [AW-1:0] pipe[LAT];
    logic          pv  [LAT];
    logic [AW-1:0] junk;
    initial begin
      for (int i = 0; i < LAT; i++) pv[i] = 1'b0;
      junk = '0;
    end
    always @(posedge clk) begin
      pv[0]   <= mac_vld[g];
      pipe[0] <= mac_z[g] + AW'(mac_x[g]) * AW'(mac_y[g]);
      for (int i = 1; i < LAT; i++) begin
        pv[i]   <= pv[i-1];
        pipe[i] <= pipe[i-1];
      end
      junk <= AW'({$urandom(), $urandom()});
    end
    assign mac_p[g] = (pv[LAT-1] === 1'b1) ? pipe[LAT-1] : junk;

    ipsxe_floating_point_horner_seq_v1_0 #(
      .COEF_WIDTH(CW), .Z_WIDTH(ZW), .ACC_WIDTH(AW), .NUM_COEF(N),
      .MAC_LATENCY(LAT), .MUL_SHIFT(0)
    ) u_dut (
      .i_clk      (clk),
      .i_rst_n    (rst_n),
      .i_valid    (valid[g]),
      .o_ready    (rdy[g]),
      .i_z        (z[g]),
      .i_coefs    (coefs[g][N*CW-1:0]),
      .o_mac_vld  (mac_vld[g]),
      .o_mac_x    (mac_x[g]),
      .o_mac_y    (mac_y[g]),
      .o_mac_z    (mac_z[g]),
      .i_mac_p    (mac_p[g]),
      .o_valid    (ovalid[g]),
      .i_ready    (iready[g]),
      .o_result   (result[g]),
      .o_dbg_state(dbg[g])
    );
  end

  // Reference model: Horner evaluation with plain modular arithmetic.
  function automatic logic [AW-1:0] ref_horner(input logic [NMAX*CW-1:0] c,
                                               input logic [ZW-1:0] zz, input int n);
    logic [AW-1:0] acc;
    logic [CW-1:0] ck;
    ck  = c[(n-1)*CW +: CW];
    acc = AW'(ck);
    for (int k = n - 2; k >= 0; k--) begin
      ck  = c[k*CW +: CW];
      acc = AW'(ck) + AW'(acc[CW-1:0]) * AW'(zz);
    end
    return acc;
  endfunction

  function automatic int ref_latency(input int n, input int lat);
    return 1 + (n - 1) * (lat + 1);
  endfunction

  // Scoreboard state
  logic [AW-1:0] exp_q[$];
  logic [AW-1:0] iss_z[$];
  int            n_iss, bp_bad, t0, td;
  logic          post_idle;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Driver: one request on instance g, result held back for 'hold' cycles.
  task automatic run_eval(input int g, input logic [NMAX*CW-1:0] c, input logic [ZW-1:0] zz,
                          input int hold, output logic [AW-1:0] res, output int lat);
    iss_z.delete();
    n_iss = 0; bp_bad = 0; lat = -1; res = '0; post_idle = 1'b0;
    iready[g] = 1'b0;
    valid[g]  = 1'b1;
    z[g]      = zz;
    coefs[g]  = c;
    for (int w = 0; w < 50 && rdy[g] !== 1'b1; w++) step();
    t0 = cyc;
    step();
    valid[g] = 1'b0;
    z[g]     = ZW'($urandom());
    coefs[g] = {$urandom(), $urandom(), $urandom()};
    for (int d = 1; d < 200; d++) begin
      if (mac_vld[g] === 1'b1) begin
        n_iss++;
        iss_z.push_back(mac_z[g]);
      end
      if (ovalid[g] === 1'b1) begin
        lat = cyc - t0;
        break;
      end
      step();
    end
    if (lat < 0) begin
      $display("FAIL timeout inst=%0d: o_valid never seen", g);
      errors++;
      return;
    end
    res = result[g];
    for (int h = 0; h < hold; h++) begin
      step();
      if (ovalid[g] !== 1'b1 || result[g] !== res || rdy[g] !== 1'b0 || mac_vld[g] !== 1'b0)
        bp_bad++;
    end
    iready[g] = 1'b1;
    td = cyc;
    step();
    iready[g] = 1'b0;
    post_idle = (rdy[g] === 1'b1) && (ovalid[g] === 1'b0);
  endtask

  localparam logic [NMAX*CW-1:0] BASIC = {22'd1, 22'd2, 22'd3, 22'd4};

  task automatic test_reset();
    rst_n = 1'b0;
    for (int g = 0; g < NI; g++) begin
      valid[g] = 1'b1; z[g] = ZW'($urandom()); coefs[g] = BASIC; iready[g] = 1'b0;
    end
    for (int i = 0; i < 4; i++) step();
    for (int g = 0; g < NI; g++) begin
      checks++;
      if ({mac_vld[g], ovalid[g], result[g], mac_x[g], mac_y[g], mac_z[g]} !== '0 || rdy[g] !== 1'b1) begin
        $display("FAIL reset_hold inst=%0d: vld=%b ovalid=%b res=%h ready=%b, required zeros and ready=1",
                 g, mac_vld[g], ovalid[g], result[g], rdy[g]);
        errors++;
      end
    end
    for (int g = 0; g < NI; g++) valid[g] = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    for (int g = 0; g < NI; g++) begin
      checks++;
      if ({mac_vld[g], ovalid[g], result[g], mac_x[g], mac_y[g], mac_z[g]} !== '0 || rdy[g] !== 1'b1) begin
        $display("FAIL reset_release inst=%0d: vld=%b ovalid=%b res=%h ready=%b, required zeros and ready=1",
                 g, mac_vld[g], ovalid[g], result[g], rdy[g]);
        errors++;
      end
    end
  endtask

  task automatic test_basic();
    logic [AW-1:0] res; int lat;
    logic [AW-1:0] exp_z[3];
    exp_z = '{47'd2, 47'd3, 47'd4};
    run_eval(0, BASIC, 9'd2, 0, res, lat);
    checks++; if (res !== 47'd26) begin $display("FAIL basic_result: got %0d, required 26", res); errors++; end
    checks++; if (lat !== 10) begin $display("FAIL basic_latency: got %0d, required 10", lat); errors++; end
    checks++; if (n_iss !== 3) begin $display("FAIL basic_issues: got %0d, required 3", n_iss); errors++; end
    if (iss_z.size() == 3) begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (iss_z[i] !== exp_z[i]) begin
          $display("FAIL basic_mac_z[%0d]: got %0d, required %0d", i, iss_z[i], exp_z[i]); errors++;
        end
      end
    end
    checks++; if (post_idle !== 1'b1) begin $display("FAIL basic_idle_after: got %b, required 1", post_idle); errors++; end
  endtask

  task automatic test_single();
    logic [AW-1:0] res; int lat;
    run_eval(1, {66'd0, 22'h1234}, ZW'($urandom()), 0, res, lat);
    checks++; if (res !== 47'h1234) begin $display("FAIL single_result: got %h, required 1234", res); errors++; end
    checks++; if (lat !== 1) begin $display("FAIL single_latency: got %0d, required 1", lat); errors++; end
    checks++; if (n_iss !== 0) begin $display("FAIL single_issues: got %0d, required 0", n_iss); errors++; end
  endtask

  task automatic test_backpressure();
    logic [AW-1:0] res; int lat;
    run_eval(0, BASIC, 9'd2, 5, res, lat);
    checks++; if (res !== 47'd26) begin $display("FAIL bp_result: got %0d, required 26", res); errors++; end
    checks++; if (bp_bad !== 0) begin $display("FAIL bp_hold: %0d bad cycles, required 0", bp_bad); errors++; end
    checks++; if (post_idle !== 1'b1) begin $display("FAIL bp_idle_after: got %b, required 1", post_idle); errors++; end
  endtask

  task automatic test_back_to_back();
    logic [AW-1:0] res; int lat; int td1;
    run_eval(0, BASIC, 9'd2, 0, res, lat);
    td1 = td;
    checks++; if (res !== 47'd26) begin $display("FAIL b2b_first: got %0d, required 26", res); errors++; end
    run_eval(0, BASIC, 9'd3, 0, res, lat);
    checks++; if (res !== 47'd58) begin $display("FAIL b2b_second: got %0d, required 58", res); errors++; end
    checks++; if (t0 !== td1 + 1) begin $display("FAIL b2b_accept: accept at %0d, required %0d", t0, td1 + 1); errors++; end
  endtask

  task automatic test_reset_mid();
    logic [AW-1:0] res; int lat; int bad;
    valid[0] = 1'b1; z[0] = 9'd2; coefs[0] = BASIC; iready[0] = 1'b0;
    for (int w = 0; w < 50 && rdy[0] !== 1'b1; w++) step();
    t0 = cyc;
    step();
    valid[0] = 1'b0;
    for (int i = 0; i < 4; i++) step();   // now in T0+5, second WAIT
    rst_n = 1'b0;
    step();
    checks++;
    if (mac_vld[0] !== 1'b0 || ovalid[0] !== 1'b0 || rdy[0] !== 1'b1) begin
      $display("FAIL midreset_state: vld=%b ovalid=%b ready=%b, required 0 0 1", mac_vld[0], ovalid[0], rdy[0]);
      errors++;
    end
    rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      if (ovalid[0] !== 1'b0 || mac_vld[0] !== 1'b0 || rdy[0] !== 1'b1) bad++;
      step();
    end
    checks++; if (bad !== 0) begin $display("FAIL midreset_quiet: %0d bad cycles, required 0", bad); errors++; end
    run_eval(0, BASIC, 9'd1, 0, res, lat);
    checks++; if (res !== 47'd10) begin $display("FAIL midreset_next: got %0d, required 10", res); errors++; end
  endtask

  task automatic test_latency_sweep();
    logic [AW-1:0] res; int lat;
    run_eval(2, BASIC, 9'd2, 0, res, lat);
    checks++; if (res !== 47'd26) begin $display("FAIL lat1_result: got %0d, required 26", res); errors++; end
    checks++; if (lat !== 7) begin $display("FAIL lat1_latency: got %0d, required 7", lat); errors++; end
    run_eval(3, BASIC, 9'd2, 0, res, lat);
    checks++; if (res !== 47'd26) begin $display("FAIL lat4_result: got %0d, required 26", res); errors++; end
    checks++; if (lat !== 16) begin $display("FAIL lat4_latency: got %0d, required 16", lat); errors++; end
  endtask

  task automatic test_random();
    logic [AW-1:0] res, exp_r; int lat, g, exp_l;
    logic [NMAX*CW-1:0] c;
    logic [ZW-1:0] zz;
    int sel[3] = '{0, 2, 3};
    for (int r = 0; r < 9; r++) begin
      g = sel[r % 3];
      for (int k = 0; k < NMAX; k++) c[k*CW +: CW] = CW'($urandom());
      zz = ZW'($urandom());
      exp_q.push_back(ref_horner(c, zz, n_of[g]));
      exp_l = ref_latency(n_of[g], lat_of[g]);
      run_eval(g, c, zz, $urandom_range(0, 3), res, lat);
      exp_r = exp_q.pop_front();
      checks++;
      if (res !== exp_r) begin
        $display("FAIL rand_result[%0d] inst=%0d: got %h, required %h", r, g, res, exp_r); errors++;
      end
      checks++;
      if (lat !== exp_l) begin
        $display("FAIL rand_latency[%0d] inst=%0d: got %0d, required %0d", r, g, lat, exp_l); errors++;
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_single();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_latency_sweep();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
